// File: rtl/geo_pkg.sv
// Shared definitions for the geometric-forms dispatch path: latencies,
// polygon memory entry layout and dispatcher FSM encoding.
package geo_pkg;

    localparam int unsigned PIPE_LATENCY = 3;
    localparam int unsigned RES_W        = 4;
    localparam logic [RES_W-1:0] HIT_MASK = 4'hF;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned REF_W   = 9;
    localparam int unsigned COLOR_W = 9;
    localparam int unsigned MULT_W  = 4;
    localparam int unsigned ENTRY_W = 33;

    localparam int unsigned VALID_B   = 32;
    localparam int unsigned FORM_B    = 31;
    localparam int unsigned MULT_LSB  = 27;
    localparam int unsigned COLOR_LSB = 18;
    localparam int unsigned REFY_LSB  = 9;
    localparam int unsigned REFX_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               form;
        logic [MULT_W-1:0]  mult;
        logic [COLOR_W-1:0] color;
        logic [REF_W-1:0]   ref_y;
        logic [REF_W-1:0]   ref_x;
    } poly_entry_t;

    // Split a raw memory word into its named fields.
    function automatic poly_entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        poly_entry_t e;
        e.valid = raw[VALID_B];
        e.form  = raw[FORM_B];
        e.mult  = raw[MULT_LSB  +: MULT_W];
        e.color = raw[COLOR_LSB +: COLOR_W];
        e.ref_y = raw[REFY_LSB  +: REF_W];
        e.ref_x = raw[REFX_LSB  +: REF_W];
        return e;
    endfunction

endpackage

// File: rtl/polygon_hit_collector.sv
// First-hit latch for pipeline results; selects the winning colour or the
// background. A hit in the current cycle is forwarded so the last slot counts.
module polygon_hit_collector
    import geo_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               active,
    input  logic [RES_W-1:0]   res_reg,
    input  logic [COLOR_W-1:0] res_color,
    input  logic               res_bubble,
    input  logic [COLOR_W-1:0] bg_color,
    output logic [COLOR_W-1:0] color_sel_c
);

    logic               hit_q;
    logic [COLOR_W-1:0] color_q;
    logic               hit_now_c;

    assign hit_now_c = active && !res_bubble && (res_reg == HIT_MASK);

    // Only the first hit is kept, so the lowest polygon index wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q   <= 1'b0;
            color_q <= '0;
        end else if (clear) begin
            hit_q   <= 1'b0;
            color_q <= '0;
        end else if (hit_now_c && !hit_q) begin
            hit_q   <= 1'b1;
            color_q <= res_color;
        end
    end

    always_comb begin
        color_sel_c = bg_color;
        if (hit_q) begin
            color_sel_c = color_q;
        end else if (hit_now_c) begin
            color_sel_c = res_color;
        end
    end

endmodule

// File: rtl/polygon_dispatch.sv
// Per-pixel polygon issuer: walks polygon memory, feeds the geometry pipeline
// one slot per cycle and reports the lowest-index hit colour.
module polygon_dispatch
    import geo_pkg::*;
#(
    parameter int unsigned N_POLY = 32,
    parameter int unsigned AW     = $clog2(N_POLY)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_start,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               busy,
    output logic               overrun,
    output logic [AW-1:0]      mem_addr,
    input  logic [ENTRY_W-1:0] mem_rdata,
    output logic               pipe_bubble,
    output logic [COORD_W-1:0] pipe_pixel_x,
    output logic [COORD_W-1:0] pipe_pixel_y,
    output logic [REF_W-1:0]   pipe_ref_x,
    output logic [REF_W-1:0]   pipe_ref_y,
    output logic [COLOR_W-1:0] pipe_color,
    output logic [MULT_W-1:0]  pipe_mult,
    output logic               pipe_form,
    input  logic [RES_W-1:0]   res_reg,
    input  logic [COLOR_W-1:0] res_color,
    input  logic               res_bubble,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               color_valid
);

    localparam int unsigned DRAIN_W = $clog2(PIPE_LATENCY + 1);

    state_t               state;
    state_t               next_state;
    logic [AW-1:0]        addr_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 fetch_d;
    logic [COORD_W-1:0]   px_q;
    logic [COORD_W-1:0]   py_q;
    logic [COLOR_W-1:0]   bg_q;
    poly_entry_t          held_q;
    logic [COORD_W-1:0]   held_px_q;
    logic [COORD_W-1:0]   held_py_q;
    poly_entry_t          rd_entry_c;
    poly_entry_t          issue_c;
    logic [COORD_W-1:0]   issue_px_c;
    logic [COORD_W-1:0]   issue_py_c;
    logic                 start_c;
    logic                 collect_c;
    logic                 last_addr_c;
    logic                 drain_done_c;
    logic [COLOR_W-1:0]   color_sel_c;

    assign start_c      = pixel_start && (state == IDLE);
    assign collect_c    = (state == FETCH) || (state == DRAIN);
    assign last_addr_c  = (addr_cnt == AW'(N_POLY - 1));
    assign drain_done_c = (drain_cnt == DRAIN_W'(PIPE_LATENCY));
    assign rd_entry_c   = unpack_entry(mem_rdata);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pixel_start)  next_state = FETCH;
            FETCH:   if (last_addr_c)  next_state = DRAIN;
            DRAIN:   if (drain_done_c) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address walk and drain timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_cnt  <= '0;
            drain_cnt <= '0;
            fetch_d   <= 1'b0;
        end else begin
            if (start_c) begin
                addr_cnt <= '0;
            end else if (state == FETCH) begin
                addr_cnt <= addr_cnt + AW'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            fetch_d   <= (state == FETCH);
        end
    end

    // Per-pixel request capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_q <= '0;
            py_q <= '0;
            bg_q <= '0;
        end else if (start_c) begin
            px_q <= pixel_x;
            py_q <= pixel_y;
            bg_q <= bg_color;
        end
    end

    // Last issued fields, held while the pipeline input idles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_q    <= '0;
            held_px_q <= '0;
            held_py_q <= '0;
        end else if (fetch_d) begin
            held_q    <= rd_entry_c;
            held_px_q <= px_q;
            held_py_q <= py_q;
        end
    end

    assign issue_c    = fetch_d ? rd_entry_c : held_q;
    assign issue_px_c = fetch_d ? px_q : held_px_q;
    assign issue_py_c = fetch_d ? py_q : held_py_q;

    assign mem_addr     = addr_cnt;
    assign pipe_bubble  = fetch_d ? ~rd_entry_c.valid : 1'b1;
    assign pipe_pixel_x = issue_px_c;
    assign pipe_pixel_y = issue_py_c;
    assign pipe_ref_x   = issue_c.ref_x;
    assign pipe_ref_y   = issue_c.ref_y;
    assign pipe_color   = issue_c.color;
    assign pipe_mult    = issue_c.mult;
    assign pipe_form    = issue_c.form;

    polygon_hit_collector u_collector (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_c),
        .active      (collect_c),
        .res_reg     (res_reg),
        .res_color   (res_color),
        .res_bubble  (res_bubble),
        .bg_color    (bg_q),
        .color_sel_c (color_sel_c)
    );

    // Status and result outputs, loaded from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy        <= 1'b0;
            overrun     <= 1'b0;
            pixel_color <= '0;
            color_valid <= 1'b0;
        end else begin
            busy        <= (next_state != IDLE);
            color_valid <= (next_state == DONE);
            if (pixel_start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            if (next_state == DONE) begin
                pixel_color <= color_sel_c;
            end
        end
    end

endmodule

// File: tb/tb_polygon_dispatch.sv
// Directed bench for polygon_dispatch with N_POLY=4, a registered polygon
// memory and a three-stage pipeline model that echoes mult as the edge result.
module tb_polygon_dispatch;

    localparam int unsigned N = 4;
    localparam int unsigned EXP_VC = N + 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pixel_start;
    logic [9:0]  pixel_x, pixel_y;
    logic [8:0]  bg_color;
    logic        busy, overrun;
    logic [1:0]  mem_addr;
    logic [32:0] mem_rdata = '0;
    logic        pipe_bubble;
    logic [9:0]  pipe_pixel_x, pipe_pixel_y;
    logic [8:0]  pipe_ref_x, pipe_ref_y, pipe_color;
    logic [3:0]  pipe_mult;
    logic        pipe_form;
    logic [3:0]  res_reg;
    logic [8:0]  res_color;
    logic        res_bubble;
    logic [8:0]  pixel_color;
    logic        color_valid;

    logic [32:0] mem [N];
    logic        s1_b = 1'b1, s2_b = 1'b1, s3_b = 1'b1;
    logic [3:0]  s1_r = '0, s2_r = '0, s3_r = '0;
    logic [8:0]  s1_c = '0, s2_c = '0, s3_c = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    polygon_dispatch #(.N_POLY(N)) dut (
        .clk(clk), .reset(reset_n), .pixel_start(pixel_start),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .bg_color(bg_color),
        .busy(busy), .overrun(overrun), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pipe_bubble(pipe_bubble), .pipe_pixel_x(pipe_pixel_x), .pipe_pixel_y(pipe_pixel_y),
        .pipe_ref_x(pipe_ref_x), .pipe_ref_y(pipe_ref_y), .pipe_color(pipe_color),
        .pipe_mult(pipe_mult), .pipe_form(pipe_form),
        .res_reg(res_reg), .res_color(res_color), .res_bubble(res_bubble),
        .pixel_color(pixel_color), .color_valid(color_valid)
    );

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    always @(posedge clk) begin
        s1_b <= pipe_bubble; s1_r <= pipe_mult; s1_c <= pipe_color;
        s2_b <= s1_b;        s2_r <= s1_r;      s2_c <= s1_c;
        s3_b <= s2_b;        s3_r <= s2_r;      s3_c <= s2_c;
    end
    assign res_bubble = s3_b;
    assign res_reg    = s3_r;
    assign res_color  = s3_c;

    function automatic logic [32:0] mk(input logic v, input logic [3:0] m, input logic [8:0] c);
        return {v, v, m, c, c ^ 9'h1FF, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one pixel and follow it to its colour strobe (bounded).
    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y, input logic [8:0] bg,
                             input int inject_at, output logic [8:0] col, output int vc,
                             output int nb, output logic [9:0] px, output logic [28:0] iss3);
        vc = -1; nb = 0; col = '0; px = '0; iss3 = '0;
        @(negedge clk);
        pixel_start = 1'b1; pixel_x = x; pixel_y = y; bg_color = bg;
        @(posedge clk); #1;
        pixel_start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (!pipe_bubble) nb++;
            if (cyc == 2) px = pipe_pixel_x;
            if (cyc == 3) iss3 = {pipe_form, pipe_ref_y, pipe_ref_x, pipe_pixel_y};
            if (color_valid) begin
                vc = cyc; col = pixel_color;
                break;
            end
            if (cyc == inject_at) begin
                @(negedge clk); pixel_start = 1'b1;
            end
            @(posedge clk); #1;
            pixel_start = 1'b0;
        end
        if (vc >= 0) begin
            @(posedge clk); #1;
            check("strobe_one_cycle", 32'(color_valid), 32'h0);
            check("idle_after_done", 32'(busy), 32'h0);
        end
    endtask

    logic [8:0]  col;
    logic [9:0]  px;
    logic [28:0] iss3;
    int          vc, nb, seen;

    initial begin
        reset_n = 1'b0; pixel_start = 1'b0; pixel_x = '0; pixel_y = '0; bg_color = '0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_pipe_bubble", 32'(pipe_bubble), 32'h1);
        check("rst_pipe_color", 32'(pipe_color), 32'h0);
        check("rst_pipe_pixel_x", 32'(pipe_pixel_x), 32'h0);
        check("rst_pixel_color", 32'(pixel_color), 32'h0);
        check("rst_color_valid", 32'(color_valid), 32'h0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // All slots empty: background colour.
        run_pixel(10'd100, 10'd50, 9'h1A5, 0, col, vc, nb, px, iss3);
        check("empty_color", 32'(col), 32'h1A5);
        check("empty_latency", 32'(vc), EXP_VC);
        check("empty_issued", 32'(nb), 32'h0);
        check("empty_pixel_x", 32'(px), 32'd100);
        repeat (2) @(posedge clk);

        // Two hits: the lower index wins.
        mem[0] = mk(1'b0, 4'h0, 9'h000); mem[1] = mk(1'b1, 4'hF, 9'h0F0);
        mem[2] = mk(1'b0, 4'h0, 9'h000); mem[3] = mk(1'b1, 4'hF, 9'h00F);
        run_pixel(10'd7, 10'd300, 9'h1A5, 0, col, vc, nb, px, iss3);
        check("two_hits_color", 32'(col), 32'h0F0);
        check("two_hits_latency", 32'(vc), EXP_VC);
        check("two_hits_issued", 32'(nb), 32'd2);
        check("slot1_issue_fields", 32'(iss3), 32'({1'b1, 9'h10F, 9'h0F0, 10'd300}));
        repeat (2) @(posedge clk);

        // Partial edge result ignored; hit on last slot lands at the drain boundary.
        mem[0] = mk(1'b0, 4'h0, 9'h000); mem[1] = mk(1'b0, 4'h0, 9'h000);
        mem[2] = mk(1'b1, 4'hE, 9'h0AA); mem[3] = mk(1'b1, 4'hF, 9'h111);
        run_pixel(10'd1, 10'd2, 9'h033, 0, col, vc, nb, px, iss3);
        check("partial_color", 32'(col), 32'h111);
        check("partial_latency", 32'(vc), EXP_VC);
        check("partial_issued", 32'(nb), 32'd2);
        repeat (2) @(posedge clk);

        // Back-to-back pixels; empty slot with full-edge garbage must not hit.
        mem[0] = mk(1'b0, 4'hF, 9'h1FF); mem[1] = mk(1'b1, 4'h7, 9'h0CC);
        mem[2] = mk(1'b1, 4'hF, 9'h055); mem[3] = mk(1'b1, 4'hF, 9'h0EE);
        run_pixel(10'd10, 10'd20, 9'h100, 0, col, vc, nb, px, iss3);
        check("b2b_a_color", 32'(col), 32'h055);
        check("b2b_a_latency", 32'(vc), EXP_VC);
        check("b2b_a_issued", 32'(nb), 32'd3);
        mem[2] = mk(1'b1, 4'h3, 9'h055);
        run_pixel(10'd11, 10'd21, 9'h101, 0, col, vc, nb, px, iss3);
        check("b2b_b_color", 32'(col), 32'h0EE);
        check("b2b_b_latency", 32'(vc), EXP_VC);
        check("b2b_no_overrun", 32'(overrun), 32'h0);
        repeat (2) @(posedge clk);

        // Start while busy: dropped, sticky overrun, timing unchanged.
        mem[0] = mk(1'b0, 4'h0, 9'h000); mem[1] = mk(1'b0, 4'h0, 9'h000);
        mem[2] = mk(1'b1, 4'hE, 9'h0AA); mem[3] = mk(1'b1, 4'hF, 9'h111);
        run_pixel(10'd5, 10'd6, 9'h022, 3, col, vc, nb, px, iss3);
        check("overrun_color", 32'(col), 32'h111);
        check("overrun_latency", 32'(vc), EXP_VC);
        check("overrun_flag", 32'(overrun), 32'h1);
        repeat (4) @(posedge clk); #1;
        check("overrun_sticky", 32'(overrun), 32'h1);

        // Reset mid-evaluation at cycle 4.
        mem[0] = mk(1'b1, 4'hF, 9'h0F0); mem[1] = mk(1'b1, 4'hF, 9'h0F1);
        mem[2] = mk(1'b1, 4'hF, 9'h0F2); mem[3] = mk(1'b1, 4'hF, 9'h0F3);
        @(negedge clk); pixel_start = 1'b1; bg_color = 9'h1C0;
        @(posedge clk); #1; pixel_start = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset_n = 1'b0; #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_pipe_bubble", 32'(pipe_bubble), 32'h1);
        check("midrst_overrun", 32'(overrun), 32'h0);
        check("midrst_mem_addr", 32'(mem_addr), 32'h0);
        @(negedge clk) reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (color_valid) seen++;
        end
        check("midrst_no_strobe", 32'(seen), 32'h0);

        // Fresh pixel after reset.
        mem[0] = mk(1'b0, 4'h0, 9'h000); mem[1] = mk(1'b1, 4'hF, 9'h0F0);
        mem[2] = mk(1'b0, 4'h0, 9'h000); mem[3] = mk(1'b1, 4'hF, 9'h00F);
        run_pixel(10'd9, 10'd9, 9'h1A5, 0, col, vc, nb, px, iss3);
        check("fresh_color", 32'(col), 32'h0F0);
        check("fresh_latency", 32'(vc), EXP_VC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
